uart_peripheral: RTL
====================

UART_PERIPHERAL -- requirements
Module: uart_peripheral

Interface
REQ-001 Parameter DIV_RESET, default 32'd5208, reset value of the baud divisor (clocks per bit; 50 MHz / 9600).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Select  input  1  chip select from memory map decoder (UART window).
REQ-005 Write  input  1  write strobe; qualified by Select.
REQ-006 Addr  input  32  word offset within UART window; only Addr[2:0] decoded.
REQ-007 DataIn  input  32  write data from processor.
REQ-008 DataOut  output  32  read data to processor.
REQ-009 rx  input  1  serial receive line, asynchronous, idle high.
REQ-010 tx  output  1  serial transmit line, idle high.
REQ-011 irq  output  1  high while rx_ready=1.

Function
REQ-012 Register map (word offset): 0 TX_DATA[7:0] RW; 1 TX_CTRL: write bit0=1 starts TX, read {31'b0,tx_busy}; 2 RX_DATA[7:0] RO; 3 RX_STAT: read {29'b0,frame_err,overrun,rx_ready}, any write clears all three; 4 BAUD_DIV[31:0] RW; 5-7 read 0, writes ignored.
REQ-013 Register write occurs on clock edge where Select=1 and Write=1; no write effect when Select=0.
REQ-014 DataOut combinational: selected register per REQ-012 when Select=1; 32'h0 when Select=0.
REQ-015 Frame format 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit = divisor clocks.
REQ-016 TX FSM states IDLE, START, DATA, STOP; tx_busy=1 in all states except IDLE.
REQ-017 IDLE->START on TX_CTRL write with bit0=1; TX_DATA and BAUD_DIV latched into shift register and bit timer at that edge; tx driven low from next cycle.
REQ-018 Start request while tx_busy=1 ignored; TX_DATA write while busy updates register only, not the frame in flight.
REQ-019 START->DATA after divisor clocks; DATA->STOP after 8th bit period; STOP->IDLE after divisor clocks with tx=1; total frame = 10*divisor clocks.
REQ-020 rx passes through 2-flop synchronizer before any use (2-cycle latency).
REQ-021 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge; divisor latched at this edge.
REQ-022 START: at divisor/2 clocks, sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags changed).
REQ-023 DATA: sample each bit at divisor clocks after previous sample (mid-bit), shift in LSB first; after 8th sample -> STOP.
REQ-024 STOP sample 1: RX_DATA<=byte, rx_ready<=1, overrun<=1 if rx_ready already 1 (new byte overwrites); STOP sample 0: frame_err<=1, RX_DATA and rx_ready unchanged; then -> IDLE.
REQ-025 Simultaneous RX_STAT clear write and flag set in same cycle: set wins.
REQ-026 BAUD_DIV writes with value <4 ignored (register keeps previous value); writes mid-frame take effect at next frame start.
REQ-027 Bit timers are counters 0..divisor-1, 32-bit, no wrap beyond divisor-1.
REQ-028 TX and RX operate fully independently; loopback (tx tied to rx) legal.

Reset
REQ-029 On rst=1 at clock edge: both FSMs->IDLE, tx=1, tx_busy=0, TX_DATA=0, RX_DATA=0, rx_ready=overrun=frame_err=0, irq=0, BAUD_DIV=DIV_RESET, synchronizer flops=1.
REQ-030 rst asserted mid-frame aborts frame immediately; tx high on cycle after reset edge; partial RX byte discarded.
REQ-031 rst has priority over any simultaneous register write.

Verification
REQ-032 Reset then read Addr 4 -> DataOut=32'd5208; Addr 1 -> 0; tx=1.
REQ-033 BAUD_DIV=16, TX_DATA=8'hA5, TX_CTRL=1 -> tx pattern 0,1,0,1,0,0,1,0,1,1 each 16 clocks; tx_busy high exactly 160 clocks.
REQ-034 BAUD_DIV=16, loopback, send 8'h3C -> RX_DATA=8'h3C, rx_ready=1, irq=1; write Addr 3 -> flags 0.
REQ-035 Two bytes 8'h11, 8'h22 received without clear -> RX_DATA=8'h22, RX_STAT=3'b011.
REQ-036 rx low 4 clocks then high (divisor 16) -> no reception, RX_STAT=0; rx stop bit forced 0 -> frame_err=1, rx_ready=0.
REQ-037 Start TX then rst after 50 clocks -> tx=1 next cycle, tx_busy=0; BAUD_DIV write of 3 -> read back unchanged.

Source files
------------

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART with a programmable baud divisor.
// The TX and RX engines are independent FSMs that share only the divisor register.
module uart_peripheral #(
  parameter logic [31:0] DIV_RESET = 32'd5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Select,
  input  logic        Write,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  typedef enum logic [1:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_STOP} tx_state_t;
  typedef enum logic [1:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_STOP} rx_state_t;

  logic [2:0]  addr;
  logic        wr;
  logic        tx_start_req;
  logic        stat_clear;
  logic        unused_addr;

  logic [7:0]  tx_data;
  logic [31:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        overrun;
  logic        frame_err;

  tx_state_t   tx_state, tx_state_n;
  logic [31:0] tx_cnt, tx_cnt_n;
  logic [31:0] tx_div, tx_div_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        tx_last;
  logic        tx_busy;

  rx_state_t   rx_state, rx_state_n;
  logic [31:0] rx_cnt, rx_cnt_n;
  logic [31:0] rx_div, rx_div_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic        rx_last;
  logic        rx_half;
  logic        rx_set_ready;
  logic        rx_set_ferr;
  logic        rx_s1, rx_s2, rx_s3;
  logic        rx_fall;

  assign addr         = Addr[2:0];
  assign unused_addr  = ^Addr[31:3];
  assign wr           = Select & Write;
  assign tx_start_req = wr && (addr == 3'd1) && DataIn[0];
  assign stat_clear   = wr && (addr == 3'd3);
  assign irq          = rx_ready;

  // Register file; a flag set from the receiver wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= 8'h00;
      baud_div  <= DIV_RESET;
      rx_data   <= 8'h00;
      rx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr && (addr == 3'd0))
        tx_data <= DataIn[7:0];
      if (wr && (addr == 3'd4) && (DataIn >= 32'd4))
        baud_div <= DataIn;
      if (stat_clear) begin
        rx_ready  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_set_ready) begin
        rx_data  <= rx_shift;
        rx_ready <= 1'b1;
        if (rx_ready)
          overrun <= 1'b1;
      end
      if (rx_set_ferr)
        frame_err <= 1'b1;
    end
  end

  always_comb begin
    DataOut = 32'h0;
    if (Select) begin
      case (addr)
        3'd0:    DataOut = {24'h0, tx_data};
        3'd1:    DataOut = {31'h0, tx_busy};
        3'd2:    DataOut = {24'h0, rx_data};
        3'd3:    DataOut = {29'h0, frame_err, overrun, rx_ready};
        3'd4:    DataOut = baud_div;
        default: DataOut = 32'h0;
      endcase
    end
  end

  // Transmit engine state
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TXS_IDLE;
      tx_cnt   <= 32'h0;
      tx_div   <= DIV_RESET;
      tx_shift <= 8'h00;
      tx_bit   <= 3'd0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
    end
  end

  assign tx_last = (tx_cnt == tx_div - 32'd1);
  assign tx_busy = (tx_state != TXS_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    case (tx_state)
      TXS_IDLE: begin
        if (tx_start_req) begin
          tx_state_n = TXS_START;
          tx_shift_n = tx_data;
          tx_div_n   = baud_div;
          tx_cnt_n   = 32'h0;
          tx_bit_n   = 3'd0;
        end
      end
      TXS_START: begin
        tx_cnt_n = tx_cnt + 32'd1;
        if (tx_last) begin
          tx_cnt_n   = 32'h0;
          tx_state_n = TXS_DATA;
        end
      end
      TXS_DATA: begin
        tx_cnt_n = tx_cnt + 32'd1;
        if (tx_last) begin
          tx_cnt_n = 32'h0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TXS_STOP;
          end else begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_bit_n   = tx_bit + 3'd1;
          end
        end
      end
      TXS_STOP: begin
        tx_cnt_n = tx_cnt + 32'd1;
        if (tx_last) begin
          tx_cnt_n   = 32'h0;
          tx_state_n = TXS_IDLE;
        end
      end
      default: tx_state_n = TXS_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state)
      TXS_START: tx = 1'b0;
      TXS_DATA:  tx = tx_shift[0];
      default:   tx = 1'b1;
    endcase
  end

  // rx is asynchronous: two flops to resolve metastability, a third for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // Receive engine state
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RXS_IDLE;
      rx_cnt   <= 32'h0;
      rx_div   <= DIV_RESET;
      rx_shift <= 8'h00;
      rx_bit   <= 3'd0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
    end
  end

  assign rx_last = (rx_cnt == rx_div - 32'd1);
  assign rx_half = (rx_cnt == (rx_div >> 1) - 32'd1);

  // The start bit is checked half a bit in, so later samples land mid-bit.
  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_div_n     = rx_div;
    rx_shift_n   = rx_shift;
    rx_bit_n     = rx_bit;
    rx_set_ready = 1'b0;
    rx_set_ferr  = 1'b0;
    case (rx_state)
      RXS_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RXS_START;
          rx_div_n   = baud_div;
          rx_cnt_n   = 32'h0;
        end
      end
      RXS_START: begin
        rx_cnt_n = rx_cnt + 32'd1;
        if (rx_half) begin
          rx_cnt_n = 32'h0;
          rx_bit_n = 3'd0;
          if (!rx_s2)
            rx_state_n = RXS_DATA;
          else
            rx_state_n = RXS_IDLE;
        end
      end
      RXS_DATA: begin
        rx_cnt_n = rx_cnt + 32'd1;
        if (rx_last) begin
          rx_cnt_n   = 32'h0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7)
            rx_state_n = RXS_STOP;
          else
            rx_bit_n = rx_bit + 3'd1;
        end
      end
      RXS_STOP: begin
        rx_cnt_n = rx_cnt + 32'd1;
        if (rx_last) begin
          rx_cnt_n   = 32'h0;
          rx_state_n = RXS_IDLE;
          if (rx_s2)
            rx_set_ready = 1'b1;
          else
            rx_set_ferr = 1'b1;
        end
      end
      default: rx_state_n = RXS_IDLE;
    endcase
  end

endmodule
